ble_uart_rx: RTL
================

BLE_UART_RX -- requirements
Module: ble_uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2604; clk cycles per bit (50 MHz / 19200 baud).
REQ-002 clk  input  1  system clock; the block uses only this clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 RX  input  1  serial line from the BLE module: 8N1, LSB first, idle high.
REQ-005 rd  input  1  pop request; pops the FIFO head on the clk edge where rd=1 and rdy=1.
REQ-006 rdata  output  8  FIFO head byte; valid only while rdy=1.
REQ-007 rdy  output  1  FIFO non-empty.
REQ-008 overrun  output  1  sticky flag: a received byte was dropped because the FIFO was full.
REQ-009 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer; all logic uses the synchronized value.
REQ-011 Receiver FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE: a synchronized falling edge of RX SHALL load the baud counter with BAUD_DIV/2 and enter START.
REQ-013 START: at counter expiry, RX high SHALL return the FSM to IDLE (false start, no byte); RX low SHALL reload BAUD_DIV and enter DATA.
REQ-014 DATA: one sample per BAUD_DIV expiry, shifted in LSB first; after the 8th sample the FSM enters STOP with a BAUD_DIV reload.
REQ-015 STOP: at expiry the stop bit is sampled, the byte is either pushed or dropped per REQ-016/REQ-017 and REQ-027, and the FSM returns to IDLE in the same cycle.
REQ-016 A push SHALL make rdy=1 on the clk edge after the stop-bit sample.
REQ-017 Push while the FIFO is full and rd=0: byte dropped, overrun set to 1; FIFO contents unchanged.
REQ-018 Push while full with a simultaneous valid pop: pop and push both take effect; no overrun.
REQ-019 rd while empty SHALL be ignored; a simultaneous push still occurs.
REQ-020 overrun SHALL clear on the first valid pop after it was set.
REQ-021 The FIFO SHALL be 4 entries, circular; pointer wrap occurs at 4, and full/empty are distinguished by a count register (0..4).
REQ-022 Back-to-back frames (a start edge immediately after the stop sample) SHALL be received without loss.

Reset
REQ-023 On rst_n low, asynchronously: FSM=IDLE, FIFO empty, rdy=0, rdata=0x00, overrun=0, frame_err=0, synchronizer flops=1.
REQ-024 Reset mid-frame SHALL discard the partial byte; after release the receiver waits for a new falling edge.

Configuration
REQ-025 Macro BLE_UART_RX_FRAME_CHK_EN.
REQ-026 Defined: a stop bit sampled low pulses frame_err for one cycle and the byte is not pushed.
REQ-027 Undefined: the stop bit is not checked, every byte is pushed, and frame_err is tied to 0 (the port remains).

Structure
REQ-028 Package ble_uart_pkg SHALL hold the FSM state enum, FIFO_DEPTH=4, pointer width, and the default BAUD_DIV constant.
REQ-029 The FIFO SHALL be sub-module ble_rx_fifo (push, pop, din, dout, count); the receiver FSM, baud counter, and shifter live in ble_uart_rx.

Verification
REQ-030 Send 0x47 at BAUD_DIV -> rdy=1 and rdata=0x47 within 2 cycles of the stop-bit center; rd pulse -> rdy=0.
REQ-031 Send 0x11,0x22,0x33,0x44,0x55 with no rd -> overrun=1; successive pops return 0x11..0x44, then rdy=0; overrun clears on the first pop.
REQ-032 RX low glitch lasting BAUD_DIV/4 cycles -> no push, FSM back in IDLE, rdy stays 0.
REQ-033 Frame 0xA5 with stop bit low -> macro defined: one frame_err pulse, rdy=0; macro undefined: rdata=0xA5, frame_err=0.
REQ-034 Assert rst_n low after the 4th data bit of 0x53, then send 0x47 -> only 0x47 received.
REQ-035 FIFO full, 5th byte's stop sample coincides with rd -> no overrun; pops return bytes 2..5.

Source files
------------

// File: rtl/ble_uart_pkg.sv
// ============================================================================
// Module      : ble_uart_pkg
// Description : Shared types and constants for the BLE UART receiver slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ble_uart_pkg;

    localparam int FIFO_DEPTH       = 4;
    localparam int PTR_W            = 2;
    localparam int CNT_W            = 3;
    localparam int BAUD_DIV_DEFAULT = 2604;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/ble_rx_fifo.sv
// ============================================================================
// Module      : ble_rx_fifo
// Description : 4-entry circular byte FIFO; a count register separates full
//               from empty. Push into a full FIFO only lands alongside a pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ble_rx_fifo
    import ble_uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [7:0]       din_i,
    output logic [7:0]       dout_o,
    output logic [CNT_W-1:0] count_o
);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads 0x00 until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ble_uart_rx.sv
// ============================================================================
// Module      : ble_uart_rx
// Description : 8N1 UART receiver for a BLE module with a 4-byte receive FIFO.
//               Macro BLE_UART_RX_FRAME_CHK_EN enables stop-bit checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ble_uart_rx
    import ble_uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rd,
    output logic [7:0] rdata,
    output logic       rdy,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV);

    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             overrun_q, overrun_d;
    logic             fall;
    logic             expire;
    logic             stop_sample;
    logic             push_req;
    logic             pop_ok;
    logic             full;
    logic [CNT_W-1:0] fifo_count;

    assign fall   = rx_prev_q & ~rx_s2_q;
    assign expire = (cnt_q <= CW'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
        if (state_q != ST_IDLE && !expire) cnt_d = cnt_q - CW'(1);
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    cnt_d   = HALF_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (expire) begin
                    if (rx_s2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = FULL_LOAD;
                        bit_d   = 3'd0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (expire) begin
                    stop_sample = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef BLE_UART_RX_FRAME_CHK_EN
    logic frame_err_q;

    assign push_req  = stop_sample & rx_s2_q;
    assign frame_err = frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err_q <= 1'b0;
        else        frame_err_q <= stop_sample & ~rx_s2_q;
    end
`else
    assign push_req  = stop_sample;
    assign frame_err = 1'b0;
`endif

    assign full   = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop_ok = rd & rdy;

    // A drop only happens when no pop frees a slot in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (push_req && full && !pop_ok) overrun_d = 1'b1;
        else if (pop_ok)                 overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
        end
    end

    ble_rx_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .pop_i   (rd),
        .din_i   (shift_q),
        .dout_o  (rdata),
        .count_o (fifo_count)
    );

    assign rdy     = (fifo_count != '0);
    assign overrun = overrun_q;

endmodule

`default_nettype wire
